// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller:
// data-path width, forwarding select codes, memory-wait FSM encodings
// and the forwarding match helper.
package pipeline_hazard_ctrl_pkg;

    localparam int XLEN = 32;

    // ALU operand source selects
    localparam logic [1:0] FWD_REG = 2'b00;  // register file value
    localparam logic [1:0] FWD_MEM = 2'b10;  // result held in the M stage
    localparam logic [1:0] FWD_WB  = 2'b01;  // result held in the W stage

    // Data-memory wait FSM
    typedef enum logic [1:0] {
        HZ_RUN      = 2'b00,
        HZ_MEM_WAIT = 2'b01,
        HZ_FAULT    = 2'b10
    } hz_state_e;

    // A later stage can supply a source operand when it writes a register,
    // that register is not x0, and it is the register being read.
    function automatic logic reg_hit(input logic       wr_en,
                                     input logic [4:0] rd_addr,
                                     input logic [4:0] rs_addr);
        return wr_en && (rd_addr != 5'd0) && (rd_addr == rs_addr);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Forwarding select for one ALU operand in the E stage.
// The M stage holds the younger result, so it has priority over W.
module pipeline_hazard_ctrl_fwd_sel
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_addr,
    input  logic       reg_wr_en_m,
    input  logic [4:0] rd_addr_m,
    input  logic       reg_wr_en_w,
    input  logic [4:0] rd_addr_w,
    output logic [1:0] fwd
);

    // Priority select: M, then W, otherwise the register file
    always_comb begin
        fwd = FWD_REG;
        if (reg_hit(reg_wr_en_m, rd_addr_m, rs_addr)) begin
            fwd = FWD_MEM;
        end else if (reg_hit(reg_wr_en_w, rd_addr_w, rs_addr)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32I pipeline.
// Produces forwarding selects, load-use bubbles, branch flushes and a
// whole-pipeline freeze while the data memory is busy, guarded by a
// watchdog that latches a sticky fault.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise the counter ports read as 0.
//
// Handshake note: i_dmem_ready acts as the ready half of a valid/ready pair
// with i_mem_reqM as valid; an M-stage access completes only in a cycle where
// both are high, and the pipeline stays frozen in every other cycle of it.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [4:0]  i_rs1_addrD,
    input  logic [4:0]  i_rs2_addrD,
    input  logic [4:0]  i_rs1_addrE,
    input  logic [4:0]  i_rs2_addrE,
    input  logic [4:0]  i_rd_addrE,
    input  logic        i_result_srcE,
    input  logic        i_reg_wr_enE,
    input  logic        i_reg_wr_enM,
    input  logic        i_reg_wr_enW,
    input  logic [4:0]  i_rd_addrM,
    input  logic [4:0]  i_rd_addrW,
    input  logic        i_pc_srcE,
    input  logic        i_mem_reqM,
    input  logic        i_dmem_ready,
    output logic [1:0]  o_fwd_aE,
    output logic [1:0]  o_fwd_bE,
    output logic        o_stallF,
    output logic        o_stallD,
    output logic        o_stallE,
    output logic        o_stallM,
    output logic        o_flushD,
    output logic        o_flushE,
    output logic        o_mem_fault,
    output logic [31:0] o_cnt_lwstall,
    output logic [31:0] o_cnt_flush,
    output logic [31:0] o_cnt_memwait,
    output logic [1:0]  o_dbg_state
);

    localparam logic [TO_W-1:0] TIMEOUT_V  = TO_W'(MEM_TIMEOUT);
    localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);

    hz_state_e        state;
    hz_state_e        state_n;
    logic [TO_W-1:0]  wd_cnt;
    logic             lwstall;
    logic             memstall;

    pipeline_hazard_ctrl_fwd_sel u_fwd_a (
        .rs_addr     (i_rs1_addrE),
        .reg_wr_en_m (i_reg_wr_enM),
        .rd_addr_m   (i_rd_addrM),
        .reg_wr_en_w (i_reg_wr_enW),
        .rd_addr_w   (i_rd_addrW),
        .fwd         (o_fwd_aE)
    );

    pipeline_hazard_ctrl_fwd_sel u_fwd_b (
        .rs_addr     (i_rs2_addrE),
        .reg_wr_en_m (i_reg_wr_enM),
        .rd_addr_m   (i_rd_addrM),
        .reg_wr_en_w (i_reg_wr_enW),
        .rd_addr_w   (i_rd_addrW),
        .fwd         (o_fwd_bE)
    );

    // Load in E whose destination is read by the instruction in D
    assign lwstall = i_result_srcE && i_reg_wr_enE && (i_rd_addrE != 5'd0) &&
                     ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD));

    // Memory-wait FSM state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= HZ_RUN;
        end else begin
            state <= state_n;
        end
    end

    // Next state, freeze decision and stall/flush outputs.
    // While frozen, a taken branch in E stays in E and flushes once released.
    always_comb begin
        state_n  = state;
        memstall = 1'b0;
        case (state)
            HZ_RUN: begin
                if (i_mem_reqM && !i_dmem_ready) begin
                    state_n  = HZ_MEM_WAIT;
                    memstall = 1'b1;
                end
            end
            HZ_MEM_WAIT: begin
                if (i_dmem_ready) begin
                    state_n = HZ_RUN;
                end else begin
                    memstall = 1'b1;
                    if (TIMEOUT_EN && (wd_cnt == TIMEOUT_V)) begin
                        state_n = HZ_FAULT;
                    end
                end
            end
            HZ_FAULT: begin
                memstall = 1'b1;
            end
            default: begin
                state_n = HZ_RUN;
            end
        endcase

        if (memstall) begin
            o_stallF = 1'b1;
            o_stallD = 1'b1;
            o_stallE = 1'b1;
            o_stallM = 1'b1;
            o_flushD = 1'b0;
            o_flushE = 1'b0;
        end else begin
            o_stallF = lwstall;
            o_stallD = lwstall;
            o_stallE = 1'b0;
            o_stallM = 1'b0;
            o_flushD = i_pc_srcE;
            o_flushE = lwstall || i_pc_srcE;
        end
    end

    // Watchdog: counts MEM_WAIT cycles, saturating at the timeout value
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wd_cnt <= '0;
        end else if (state == HZ_RUN) begin
            wd_cnt <= '0;
        end else if ((state == HZ_MEM_WAIT) && (wd_cnt != TIMEOUT_V)) begin
            wd_cnt <= wd_cnt + TO_W'(1);
        end
    end

    assign o_mem_fault = (state == HZ_FAULT);
    assign o_dbg_state = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cnt_lwstall;
    logic [31:0] cnt_flush;
    logic [31:0] cnt_memwait;

    // Performance counters: bubbles, branch flushes and frozen cycles
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_lwstall <= '0;
            cnt_flush   <= '0;
            cnt_memwait <= '0;
        end else begin
            if (lwstall && !memstall) cnt_lwstall <= cnt_lwstall + 32'd1;
            if (i_pc_srcE && !memstall) cnt_flush <= cnt_flush + 32'd1;
            if (memstall) cnt_memwait <= cnt_memwait + 32'd1;
        end
    end

    assign o_cnt_lwstall = cnt_lwstall;
    assign o_cnt_flush   = cnt_flush;
    assign o_cnt_memwait = cnt_memwait;
`else
    assign o_cnt_lwstall = 32'd0;
    assign o_cnt_flush   = 32'd0;
    assign o_cnt_memwait = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl (watchdog timeout set to 4 cycles).
// Directed scenarios from the block's behaviour plus a randomized run
// checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int unsigned T = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rstn;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        res_src_e, wr_e, wr_m, wr_w, pc_src_e, mem_req_m, dmem_ready;
    logic [1:0]  fwd_a, fwd_b, dbg_state;
    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_fault;
    logic [31:0] cnt_lw, cnt_fl, cnt_mw;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .TO_W(8)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_rs1_addrD   (rs1_d),
        .i_rs2_addrD   (rs2_d),
        .i_rs1_addrE   (rs1_e),
        .i_rs2_addrE   (rs2_e),
        .i_rd_addrE    (rd_e),
        .i_result_srcE (res_src_e),
        .i_reg_wr_enE  (wr_e),
        .i_reg_wr_enM  (wr_m),
        .i_reg_wr_enW  (wr_w),
        .i_rd_addrM    (rd_m),
        .i_rd_addrW    (rd_w),
        .i_pc_srcE     (pc_src_e),
        .i_mem_reqM    (mem_req_m),
        .i_dmem_ready  (dmem_ready),
        .o_fwd_aE      (fwd_a),
        .o_fwd_bE      (fwd_b),
        .o_stallF      (stall_f),
        .o_stallD      (stall_d),
        .o_stallE      (stall_e),
        .o_stallM      (stall_m),
        .o_flushD      (flush_d),
        .o_flushE      (flush_e),
        .o_mem_fault   (mem_fault),
        .o_cnt_lwstall (cnt_lw),
        .o_cnt_flush   (cnt_fl),
        .o_cnt_memwait (cnt_mw),
        .o_dbg_state   (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- behavioural model ----------------
    // m_waiting: an M access is outstanding; m_widx: wait cycles already spent
    bit          m_waiting;
    int unsigned m_widx;
    bit          m_fault;
    logic [31:0] m_cnt_lw, m_cnt_fl, m_cnt_mw;

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (wr_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (wr_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_lw();
        return res_src_e && wr_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    endfunction

    function automatic bit m_memstall();
        if (m_fault) return 1'b1;
        if (m_waiting) return !dmem_ready;
        return mem_req_m && !dmem_ready;
    endfunction

    function automatic logic [1:0] m_state();
        if (m_fault) return HZ_FAULT;
        if (m_waiting) return HZ_MEM_WAIT;
        return HZ_RUN;
    endfunction

    task automatic model_reset();
        m_waiting = 0; m_widx = 0; m_fault = 0;
        m_cnt_lw = 0; m_cnt_fl = 0; m_cnt_mw = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_advance();
        bit ms;
        bit lw;
        ms = m_memstall();
        lw = m_lw();
        if (PERF) begin
            if (lw && !ms) m_cnt_lw = m_cnt_lw + 1;
            if (pc_src_e && !ms) m_cnt_fl = m_cnt_fl + 1;
            if (ms) m_cnt_mw = m_cnt_mw + 1;
        end
        if (m_fault) begin
            m_fault = 1;
        end else if (m_waiting) begin
            if (dmem_ready) m_waiting = 0;
            else if (T != 0 && m_widx >= T) begin m_fault = 1; m_waiting = 0; end
            else m_widx = m_widx + 1;
        end else if (mem_req_m && !dmem_ready) begin
            m_waiting = 1; m_widx = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        res_src_e = 0; wr_e = 0; wr_m = 0; wr_w = 0; pc_src_e = 0;
        mem_req_m = 0; dmem_ready = 0;
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 0;
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rstn = 0;
        model_reset();
        #1;
        checks++; if ({fwd_a, fwd_b} !== 4'b0) begin errors++; $display("FAIL reset_fwd got %b want 0000", {fwd_a, fwd_b}); end
        checks++; if ({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got %b want 000000", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}); end
        checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", mem_fault); end
        checks++; if (dbg_state !== HZ_RUN) begin errors++; $display("FAIL reset_state got %b want %b", dbg_state, HZ_RUN); end
        checks++; if ({cnt_lw, cnt_fl, cnt_mw} !== 96'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d/%0d want 0", cnt_lw, cnt_fl, cnt_mw); end
        @(posedge clk);
        #1;
        rstn = 1;
    endtask

    task automatic test_load_use();
        do_reset();
        rd_e = 5; res_src_e = 1; wr_e = 1; rs1_d = 5; rs2_d = 9;
        #1;
        checks++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin errors++; $display("FAIL lw_stall got %b want 111", {stall_f, stall_d, flush_e}); end
        checks++; if ({flush_d, stall_e, stall_m} !== 3'b000) begin errors++; $display("FAIL lw_noflushd got %b want 000", {flush_d, stall_e, stall_m}); end
        tick();
        checks++; if (cnt_lw !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL lw_cnt got %0d want %0d", cnt_lw, PERF ? 1 : 0); end
        // Bubble inserted: the load has moved on, so the stall is gone
        res_src_e = 0; wr_e = 0; rd_e = 0;
        #1;
        checks++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("FAIL lw_one_bubble got %b want 000", {stall_f, stall_d, flush_e}); end
        // A load to x0 never stalls
        res_src_e = 1; wr_e = 1; rd_e = 0; rs1_d = 0;
        #1;
        checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL lw_x0 got %b want 0", stall_f); end
        // Match on rs2 also stalls
        rd_e = 12; rs2_d = 12; rs1_d = 3;
        #1;
        checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL lw_rs2 got %b want 1", stall_d); end
        tick();
        clear_inputs();
    endtask

    task automatic test_forward();
        do_reset();
        rd_m = 7; rd_w = 7; wr_m = 1; wr_w = 1; rs2_e = 7; rs1_e = 3;
        #1;
        checks++; if (fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_m_wins got %b want 10", fwd_b); end
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_a_none got %b want 00", fwd_a); end
        wr_m = 0;
        #1;
        checks++; if (fwd_b !== 2'b01) begin errors++; $display("FAIL fwd_w_when_m_off got %b want 01", fwd_b); end
        wr_m = 1; rd_m = 0; rs2_e = 0; rd_w = 0;
        #1;
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_x0 got %b want 00", fwd_b); end
        rd_w = 3; rs1_e = 3;
        #1;
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_a_w got %b want 01", fwd_a); end
        clear_inputs();
    endtask

    task automatic test_branch_flush();
        do_reset();
        pc_src_e = 1;
        #1;
        checks++; if ({flush_d, flush_e} !== 2'b11) begin errors++; $display("FAIL br_flush got %b want 11", {flush_d, flush_e}); end
        checks++; if ({stall_f, stall_d, stall_e, stall_m} !== 4'b0) begin errors++; $display("FAIL br_nostall got %b want 0000", {stall_f, stall_d, stall_e, stall_m}); end
        tick();
        pc_src_e = 0;
        #1;
        checks++; if (cnt_fl !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL br_cnt got %0d want %0d", cnt_fl, PERF ? 1 : 0); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req_m = 1; dmem_ready = 0; pc_src_e = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e} !== 6'b111100) begin errors++; $display("FAIL memwait_cyc%0d got %b want 111100", i, {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}); end
            tick();
        end
        dmem_ready = 1;
        #1;
        checks++; if ({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e} !== 6'b000011) begin errors++; $display("FAIL memwait_release got %b want 000011", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}); end
        tick();
        clear_inputs();
        #1;
        checks++; if (cnt_mw !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL memwait_cnt got %0d want %0d", cnt_mw, PERF ? 3 : 0); end
        checks++; if (dbg_state !== HZ_RUN) begin errors++; $display("FAIL memwait_state got %b want %b", dbg_state, HZ_RUN); end
    endtask

    task automatic test_timeout_fault();
        do_reset();
        mem_req_m = 1; dmem_ready = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if ({stall_f, stall_m, mem_fault} !== 3'b110) begin errors++; $display("FAIL to_wait%0d got %b want 110", i, {stall_f, stall_m, mem_fault}); end
            tick();
        end
        checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL to_fault got %b want 1", mem_fault); end
        checks++; if (dbg_state !== HZ_FAULT) begin errors++; $display("FAIL to_state got %b want %b", dbg_state, HZ_FAULT); end
        // Fault is sticky even once memory recovers
        mem_req_m = 0; dmem_ready = 1; pc_src_e = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_fault} !== 7'b1111001) begin errors++; $display("FAIL fault_hold%0d got %b want 1111001", i, {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_fault}); end
            tick();
        end
        checks++; if (cnt_mw !== (PERF ? 32'd11 : 32'd0)) begin errors++; $display("FAIL fault_cnt got %0d want %0d", cnt_mw, PERF ? 11 : 0); end
        // Asynchronous reset away from a clock edge
        #2;
        rstn = 0;
        model_reset();
        #1;
        checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL arst_fault got %b want 0", mem_fault); end
        checks++; if (dbg_state !== HZ_RUN) begin errors++; $display("FAIL arst_state got %b want %b", dbg_state, HZ_RUN); end
        @(posedge clk);
        #1;
        rstn = 1;
        clear_inputs();
    endtask

    task automatic test_timeout_ready_wins();
        do_reset();
        mem_req_m = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) tick();
        dmem_ready = 1;
        #1;
        checks++; if ({stall_f, dbg_state} !== {1'b0, HZ_MEM_WAIT}) begin errors++; $display("FAIL rw_edge got %b want %b", {stall_f, dbg_state}, {1'b0, HZ_MEM_WAIT}); end
        tick();
        checks++; if ({mem_fault, dbg_state} !== {1'b0, HZ_RUN}) begin errors++; $display("FAIL rw_run got %b want %b", {mem_fault, dbg_state}, {1'b0, HZ_RUN}); end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [1:0] ef_a, ef_b;
        bit ms, lw;
        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            for (int c = 0; c < 50; c++) begin
                rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
                rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
                rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
                rd_w  = 5'($urandom_range(0, 3));
                res_src_e = 1'($urandom_range(0, 1)); wr_e = 1'($urandom_range(0, 1));
                wr_m = 1'($urandom_range(0, 1)); wr_w = 1'($urandom_range(0, 1));
                pc_src_e = ($urandom_range(0, 3) == 0);
                mem_req_m = 1'($urandom_range(0, 1));
                dmem_ready = ($urandom_range(0, 3) != 0);
                #1;
                ef_a = exp_fwd(rs1_e);
                ef_b = exp_fwd(rs2_e);
                ms = m_memstall();
                lw = m_lw();
                checks++; if ({fwd_a, fwd_b} !== {ef_a, ef_b}) begin errors++; $display("FAIL rnd_fwd c%0d got %b want %b", c, {fwd_a, fwd_b}, {ef_a, ef_b}); end
                checks++; if ({stall_f, stall_d, stall_e, stall_m} !== {ms | lw, ms | lw, ms, ms}) begin errors++; $display("FAIL rnd_stall c%0d got %b want %b", c, {stall_f, stall_d, stall_e, stall_m}, {ms | lw, ms | lw, ms, ms}); end
                checks++; if ({flush_d, flush_e} !== {!ms & pc_src_e, !ms & (lw | pc_src_e)}) begin errors++; $display("FAIL rnd_flush c%0d got %b want %b", c, {flush_d, flush_e}, {!ms & pc_src_e, !ms & (lw | pc_src_e)}); end
                checks++; if ({mem_fault, dbg_state} !== {m_fault, m_state()}) begin errors++; $display("FAIL rnd_state c%0d got %b want %b", c, {mem_fault, dbg_state}, {m_fault, m_state()}); end
                checks++; if ({cnt_lw, cnt_fl, cnt_mw} !== {m_cnt_lw, m_cnt_fl, m_cnt_mw}) begin errors++; $display("FAIL rnd_cnt c%0d got %0d/%0d/%0d want %0d/%0d/%0d", c, cnt_lw, cnt_fl, cnt_mw, m_cnt_lw, m_cnt_fl, m_cnt_mw); end
                tick();
            end
        end
        clear_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clear_inputs();
        rstn = 1;
        model_reset();
        #2;
        test_reset();
        test_load_use();
        test_forward();
        test_branch_flush();
        test_mem_wait();
        test_timeout_fault();
        test_timeout_ready_wins();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
